multicycle_alu: RTL and testbench
=================================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, which sets the width of the operands and the result.
REQ-002 The block SHALL have parameter SHAMT_WIDTH, default 5, which sets the width of the shift amount.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have port start, input, 1 bit, which requests an operation using the current operand inputs.
REQ-006 The block SHALL have port ALUOperation, input, 4 bits, the operation code produced by the ALU control stage.
REQ-007 The block SHALL have port A, input, DATA_WIDTH bits, operand rs.
REQ-008 The block SHALL have port B, input, DATA_WIDTH bits, operand rt or the extended immediate.
REQ-009 The block SHALL have port shamt, input, SHAMT_WIDTH bits, the shift amount for SLL and SRL.
REQ-010 The block SHALL have port busy, output, 1 bit, which is high while a shift is iterating.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle pulse that marks the result as valid.
REQ-012 The block SHALL have port ALUResult, output, DATA_WIDTH bits, the registered result.
REQ-013 The block SHALL have port Zero, output, 1 bit, which is high when ALUResult is 0; it is registered together with ALUResult.
REQ-014 The block SHALL have port Error, output, 1 bit, which is high when the last accepted code was unsupported; it is registered together with ALUResult.

Function
REQ-015 Operation encoding SHALL be: 0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 SUB, 0101 LUI, 0110 SLL, 0111 SRL; every other code (including 1001) is unsupported.
REQ-016 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-017 In IDLE, start=1 SHALL be sampled at a clock edge (E0); the operands A, B, shamt and ALUOperation are captured at that edge.
REQ-018 Non-shift codes SHALL complete at E0: ALUResult, Zero and Error are loaded, done=1 for the cycle after E0, and the FSM stays in IDLE (latency 1).
REQ-019 Arithmetic SHALL be: ADD/SUB as modulo 2^DATA_WIDTH with no overflow flag; LUI = {B[15:0], 16'b0}; AND/OR/NOR bitwise on A,B.
REQ-020 An unsupported code SHALL give ALUResult=0, Zero=1, Error=1, done pulse, latency 1.
REQ-021 A shift with shamt=0 SHALL give ALUResult=B with latency 1 and SHALL NOT enter SHIFT.
REQ-022 A shift with shamt=n>0 SHALL, at E0, load B into ALUResult, load counter=n, and enter SHIFT with busy=1.
REQ-023 In SHIFT, each edge SHALL shift ALUResult by one bit (SLL: left, zero fill; SRL: logical right, zero fill) and decrement the counter.
REQ-024 At the edge where the counter goes from 1 to 0, the FSM SHALL return to IDLE, set busy=0, and assert done for one cycle; the shift latency is n+1 cycles from E0.
REQ-025 Zero and Error SHALL be updated only on the done-producing edge; during SHIFT they hold their prior values, and Error=0 for shifts.
REQ-026 start SHALL be ignored while busy=1; no queuing.
REQ-027 start=1 in the same cycle as done=1 (FSM in IDLE) SHALL be accepted, giving back-to-back operations.
REQ-028 ALUResult, Zero and Error SHALL hold their values after done until the next accepted operation loads them.
REQ-029 done SHALL never be high for two consecutive cycles for a single operation.

Reset
REQ-030 reset=1 at an edge SHALL set: state IDLE, busy=0, done=0, ALUResult=0, Zero=1, Error=0, counter=0.
REQ-031 reset SHALL have priority over start and over SHIFT progress; a shift in progress is abandoned and no done is produced for it.
REQ-032 start=1 coincident with reset=1 SHALL be discarded.

Verification
REQ-033 The bench SHALL cover: ADD A=0x7FFFFFFF, B=1 -> one cycle later done=1, ALUResult=0x80000000, Zero=0, Error=0.
REQ-034 The bench SHALL cover: SUB A=B=0x1234 -> done after 1 cycle, ALUResult=0, Zero=1 (branch-equal case).
REQ-035 The bench SHALL cover: SLL B=0x00000001, shamt=31 -> busy high for 31 cycles, done 32 cycles after E0, ALUResult=0x80000000; a start pulse mid-shift is ignored.
REQ-036 The bench SHALL cover: SRL B=0x80000000, shamt=4, followed immediately by a start for LUI B=0xABCD in the done cycle -> results 0x08000000, then 0xABCD0000 one cycle later.
REQ-037 The bench SHALL cover: code 1001 -> done after 1 cycle, Error=1, ALUResult=0, Zero=1; then AND 0xF0F0 & 0x0FF0 -> 0x00F0, Error=0.
REQ-038 The bench SHALL cover: SLL shamt=10 with reset asserted at the 5th SHIFT cycle -> next cycle busy=0, ALUResult=0, Zero=1, and no done pulse follows.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multicycle ALU: logic and arithmetic finish one cycle after start, while SLL/SRL
// iterate one bit per clock. done pulses once per operation, and the result holds until the next accepted start.
module multicycle_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   Error
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state_reg;
  logic [SHAMT_WIDTH-1:0] count_reg;
  logic                   shift_left_reg;

  logic [DATA_WIDTH-1:0]  op_result;
  logic                   op_error;
  logic                   op_is_shift;
  logic [DATA_WIDTH-1:0]  shift_next;

  always_comb begin
    op_result   = '0;
    op_error    = 1'b0;
    op_is_shift = 1'b0;
    case (ALUOperation)
      OP_AND: op_result = A & B;
      OP_OR:  op_result = A | B;
      OP_NOR: op_result = ~(A | B);
      OP_ADD: op_result = A + B;
      OP_SUB: op_result = A - B;
      OP_LUI: op_result = DATA_WIDTH'(B[15:0]) << 16;
      OP_SLL, OP_SRL: begin
        // A zero-length shift is just B; longer shifts start from B too
        op_result   = B;
        op_is_shift = 1'b1;
      end
      default: op_error = 1'b1;
    endcase
  end

  assign shift_next = shift_left_reg ? (ALUResult << 1) : (ALUResult >> 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      shift_left_reg <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ALUResult      <= '0;
      Zero           <= 1'b1;
      Error          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (op_is_shift && shamt != '0) begin
              ALUResult      <= B;
              count_reg      <= shamt;
              shift_left_reg <= (ALUOperation == OP_SLL);
              busy           <= 1'b1;
              state_reg      <= SHIFT;
            end else begin
              ALUResult <= op_result;
              Zero      <= (op_result == '0);
              Error     <= op_error;
              done      <= 1'b1;
            end
          end
        end
        SHIFT: begin
          // Zero/Error keep their previous values until the final shift edge
          ALUResult <= shift_next;
          count_reg <= count_reg - SHAMT_WIDTH'(1);
          if (count_reg == SHAMT_WIDTH'(1)) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            Zero      <= (shift_next == '0);
            Error     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_alu.sv
// Bench for multicycle_alu: transaction-level reference model checked every cycle,
// plus directed cases with hand-computed results and latencies.
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        Error;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  multicycle_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
    .A(A), .B(B), .shamt(shamt), .busy(busy), .done(done),
    .ALUResult(ALUResult), .Zero(Zero), .Error(Error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: {error, result} of an operation, shifts computed in one step
  function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'd0: return {1'b0, a & b};
      4'd1: return {1'b0, a | b};
      4'd2: return {1'b0, ~(a | b)};
      4'd3: return {1'b0, a + b};
      4'd4: return {1'b0, a - b};
      4'd5: return {1'b0, b[15:0], 16'h0000};
      4'd6: return {1'b0, b << sh};
      4'd7: return {1'b0, b >> sh};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  int          m_left = 0;
  logic        m_done = 1'b0;
  logic [31:0] m_res  = 32'h0;
  logic        m_zero = 1'b1;
  logic        m_err  = 1'b0;
  logic [31:0] m_pend = 32'h0;
  logic [32:0] m_tmp;

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_done = 1'b0; m_res = 32'h0; m_zero = 1'b1; m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1; m_res = m_pend; m_zero = (m_pend == 0); m_err = 1'b0;
        end
      end else if (start) begin
        m_tmp = ref_alu(ALUOperation, A, B, shamt);
        if ((ALUOperation == 4'd6 || ALUOperation == 4'd7) && shamt != 0) begin
          m_left = int'(shamt);
          m_pend = m_tmp[31:0];
        end else begin
          m_done = 1'b1; m_res = m_tmp[31:0]; m_zero = (m_tmp[31:0] == 0); m_err = m_tmp[32];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy", busy, m_left > 0);
      check("model_done", done, m_done);
      if (m_left == 0) begin
        check("model_result", ALUResult, m_res);
        check("model_zero", Zero, m_zero);
        check("model_error", Error, m_err);
      end
    end
  end

  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input int exp_lat,
                        input logic [31:0] exp_res, input logic exp_z, input logic exp_e,
                        input int inject);
    int lat;
    int bcnt;
    @(negedge clk);
    start = 1'b1; ALUOperation = op; A = a; B = b; shamt = sh;
    @(negedge clk);
    start = 1'b0; lat = 1; bcnt = 0;
    while (!done && lat < 200) begin
      if (busy) bcnt++;
      if (lat == inject) begin
        start = 1'b1; ALUOperation = 4'd3; A = $urandom; B = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_busy_cycles"}, bcnt, exp_lat - 1);
    check({name, "_result"}, ALUResult, exp_res);
    check({name, "_zero"}, Zero, exp_z);
    check({name, "_error"}, Error, exp_e);
    $display("op %s: latency %0d result %h zero %0b error %0b", name, lat, ALUResult, Zero, Error);
  endtask

  initial begin
    int seen_done;
    int guard;
    reset = 1'b1; start = 1'b0; ALUOperation = 4'd0; A = 0; B = 0; shamt = 0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", ALUResult, 32'h0);
    check("reset_zero", Zero, 1);
    check("reset_error", Error, 0);
    reset = 1'b0;
    chk_en = 1'b1;

    run_op("add_overflow", 4'd3, 32'h7FFF_FFFF, 32'h1, 5'd0, 1, 32'h8000_0000, 0, 0, -1);
    run_op("sub_equal", 4'd4, 32'h1234, 32'h1234, 5'd0, 1, 32'h0, 1, 0, -1);
    run_op("sll_31", 4'd6, 32'h0, 32'h1, 5'd31, 32, 32'h8000_0000, 0, 0, 10);
    run_op("srl_4", 4'd7, 32'h0, 32'h8000_0000, 5'd4, 5, 32'h0800_0000, 0, 0, -1);
    // back-to-back: LUI accepted in the SRL done cycle
    start = 1'b1; ALUOperation = 4'd5; B = 32'h0000_ABCD;
    @(negedge clk);
    start = 1'b0;
    check("lui_b2b_done", done, 1);
    check("lui_b2b_result", ALUResult, 32'hABCD_0000);
    $display("op lui_b2b: done %0b result %h", done, ALUResult);
    run_op("unsupported_1001", 4'd9, 32'h5, 32'h7, 5'd3, 1, 32'h0, 1, 1, -1);
    run_op("and_after_err", 4'd0, 32'hF0F0, 32'h0FF0, 5'd0, 1, 32'h00F0, 0, 0, -1);
    run_op("sll_shamt0", 4'd6, 32'h0, 32'h55, 5'd0, 1, 32'h55, 0, 0, -1);
    run_op("nor_zero", 4'd2, 32'h0, 32'h0, 5'd0, 1, 32'hFFFF_FFFF, 0, 0, -1);
    run_op("srl_to_zero", 4'd7, 32'h0, 32'h0000_0003, 5'd2, 3, 32'h0, 1, 0, -1);

    // reset during the 5th SHIFT cycle of SLL by 10
    @(negedge clk);
    start = 1'b1; ALUOperation = 4'd6; B = 32'h3; shamt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_shift_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", ALUResult, 32'h0);
    check("abort_zero", Zero, 1);
    seen_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("abort_no_done", seen_done, 0);
    $display("op reset_mid_shift: busy %0b result %h zero %0b", busy, ALUResult, Zero);

    // start coincident with reset is discarded
    start = 1'b1; reset = 1'b1; ALUOperation = 4'd3; A = 32'h1; B = 32'h1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    @(negedge clk);
    check("rst_start_done", done, 0);
    check("rst_start_result", ALUResult, 32'h0);
    $display("op reset_with_start: done %0b result %h", done, ALUResult);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) == 0);
      start = ($urandom_range(0, 2) == 0);
      ALUOperation = ($urandom_range(0, 3) == 0) ? 4'(6 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
      A = $urandom;
      B = ($urandom_range(0, 7) == 0) ? A : $urandom;
      shamt = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 12));
      if (start && !busy && !reset)
        $display("txn %0d: op %0d A %h B %h shamt %0d", i, ALUOperation, A, B, shamt);
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    guard = 0;
    while (busy && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("final_idle", busy, 0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
